// File: rtl/rom_reader.sv
// Burst sequencer for an asynchronous ROM: drives address/OE, waits a settle
// time, captures each word and hands it downstream over valid/ready.
module rom_reader #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_oeb,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [ADDR_W:0] MAX_WORDS   = (ADDR_W+1)'(2**ADDR_W);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [3:0]          settle_q, settle_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                rom_oeb_q, rom_oeb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      settle_q    <= '0;
      rom_addr_q  <= '0;
      rom_oeb_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      settle_q    <= settle_d;
      rom_addr_q  <= rom_addr_d;
      rom_oeb_q   <= rom_oeb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    settle_d    = settle_q;
    rom_addr_d  = rom_addr_q;
    rom_oeb_d   = rom_oeb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            rom_addr_d = start_addr;
            rom_oeb_d  = 1'b0;
            busy_d     = 1'b1;
            rem_d      = (count > MAX_WORDS) ? MAX_WORDS : count;
            settle_d   = SETTLE_LOAD;
            state_d    = SETTLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // Capture happens on the edge after the counter has hit zero, so the
      // word is sampled SETTLE_CYCLES+1 edges after the address moved.
      SETTLE: begin
        if (settle_q == '0) begin
          out_data_d  = rom_data;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rem_d       = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) begin
            rom_oeb_d = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            settle_d   = SETTLE_LOAD;
            state_d    = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;
  assign rom_oeb   = rom_oeb_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with an asynchronous 16x8 ROM model.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] count;
  logic       busy, done, rom_oeb, out_valid, out_ready;
  logic [3:0] rom_addr;
  logic [7:0] rom_data, out_data;

  localparam logic [7:0] ROM [16] = '{
    8'h3C, 8'hA1, 8'h5E, 8'h72, 8'h09, 8'hD4, 8'h6B, 8'hE8,
    8'h17, 8'hC2, 8'h4F, 8'h90, 8'h2D, 8'hB6, 8'h81, 8'hFA
  };

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_oeb ? 8'hxx : ROM[rom_addr];

  rom_reader #(.ADDR_W(4), .DATA_W(8), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_oeb(rom_oeb),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] a, input logic [4:0] c);
    start = 1'b1; start_addr = a; count = c;
    tick();
    start = 1'b0;
  endtask

  // Runs a burst with out_ready high and checks data, addresses and timing.
  task automatic burst(input logic [3:0] a, input logic [4:0] c, input int n_exp);
    logic [3:0] exp_addr = a;
    int words = 0;
    int done_cyc = -1;
    int oe_bad = 0;
    out_ready = 1'b1;
    launch(a, c);
    check_vec("launch_busy", busy, 1);
    check_vec("launch_oeb", rom_oeb, 0);
    check_vec("launch_addr", rom_addr, a);
    for (int cyc = 1; cyc <= 3 * n_exp + 10 && done_cyc < 0; cyc++) begin
      tick();
      if (out_valid) begin
        check_vec("word_time", cyc, 2 + 3 * words);
        check_vec("word_addr", rom_addr, exp_addr);
        check_vec("word_data", out_data, ROM[exp_addr]);
        exp_addr = exp_addr + 4'd1;
        words++;
      end
      if (done) done_cyc = cyc;
      else if (rom_oeb) oe_bad++;
    end
    check_vec("words", words, n_exp);
    check_vec("done_time", done_cyc, 3 * n_exp);
    check_vec("oeb_gaps", oe_bad, 0);
    check_vec("end_busy", busy, 0);
    check_vec("end_oeb", rom_oeb, 1);
    tick();
    check_vec("done_pulse", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
    repeat (2) tick();
    check_vec("rst_oeb", rom_oeb, 1);
    check_vec("rst_addr", rom_addr, 0);
    check_vec("rst_valid", out_valid, 0);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_done", done, 0);
    check_vec("rst_data", out_data, 0);
    rst = 1'b0;
    tick();

    burst(4'd0, 5'd16, 16);   // full sweep
    burst(4'd14, 5'd4, 4);    // wrap 14,15,0,1

    // Backpressure on first word
    out_ready = 1'b0;
    launch(4'd3, 5'd2);
    tick();
    check_vec("bp_e1_valid", out_valid, 0);
    tick();
    check_vec("bp_e2_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check_vec("bp_hold_data", out_data, ROM[3]);
      check_vec("bp_hold_addr", rom_addr, 3);
      check_vec("bp_hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_vec("bp_hs_valid", out_valid, 0);
    check_vec("bp_hs_addr", rom_addr, 4);
    tick();
    tick();
    check_vec("bp_w2_valid", out_valid, 1);
    check_vec("bp_w2_data", out_data, ROM[4]);
    tick();
    check_vec("bp_done", done, 1);
    check_vec("bp_last_addr", rom_addr, 4);
    check_vec("bp_oeb", rom_oeb, 1);
    tick();

    // Zero count
    launch(4'd7, 5'd0);
    check_vec("zero_done", done, 1);
    check_vec("zero_busy", busy, 0);
    check_vec("zero_oeb", rom_oeb, 1);
    check_vec("zero_valid", out_valid, 0);
    tick();
    check_vec("zero_done_clr", done, 0);
    check_vec("zero_oeb2", rom_oeb, 1);

    burst(4'd5, 5'd31, 16);   // clamp

    // Restart ignored while busy, then abort by reset after the 2nd word
    launch(4'd8, 5'd5);
    start = 1'b1; start_addr = 4'd0; count = 5'd1;
    for (int cyc = 1; cyc <= 5; cyc++) tick();
    check_vec("ab_w2_valid", out_valid, 1);
    check_vec("ab_w2_addr", rom_addr, 9);
    check_vec("ab_w2_data", out_data, ROM[9]);
    tick();
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_vec("ab_oeb", rom_oeb, 1);
    check_vec("ab_busy", busy, 0);
    check_vec("ab_valid", out_valid, 0);
    check_vec("ab_addr", rom_addr, 0);
    check_vec("ab_done", done, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec("ab_no_done", done, 0);
    end
    burst(4'd2, 5'd3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_reader.md
Name: rom_reader

Overview:
- Sequencer sitting directly upstream of the asynchronous 16x8 ROM. It drives the ROM's 4-bit address and active-low output enable, and samples the ROM data bus after a programmable settle time.
- Each captured word is handed downstream over a valid/ready handshake.
- Turns a single start request into a burst read of consecutive ROM addresses.

Parameters:
- ADDR_W, 4, ROM address width; depth is 2**ADDR_W.
- DATA_W, 8, ROM data width.
- SETTLE_CYCLES, 1, number of clock cycles rom_data is allowed to settle after rom_addr/rom_oeb change; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- start_addr  in  ADDR_W  first ROM address of the burst.
- count  in  ADDR_W+1  number of words to read; 0 is legal; values >16 are clamped to 16.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse at burst end.
- rom_addr  out  ADDR_W  address to ROM.
- rom_oeb  out  1  ROM output enable, active low.
- rom_data  in  DATA_W  ROM data bus; high-Z or undefined while rom_oeb=1.
- out_data  out  DATA_W  captured word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.

Behaviour:
- Reset, asynchronous and immediate:
  - rom_oeb=1, rom_addr=0, out_data=0, out_valid=0, busy=0, done=0.
  - State goes to IDLE; the remaining-word and settle counters go to 0.
- All outputs are registered. rom_oeb is never low outside a burst.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - If start=1 and count!=0 at edge E0: rom_addr<=start_addr, rom_oeb<=0, busy<=1, remaining<=min(count,16), settle counter<=SETTLE_CYCLES, then go to SETTLE.
  - If start=1 and count=0: done pulses one cycle, busy stays 0, rom_oeb stays 1, no ROM access.
  - Otherwise hold.
- SETTLE:
  - The settle counter decrements each edge.
  - On the edge where it reaches 0: out_data<=rom_data, out_valid<=1, go to HOLD.
  - Result: out_valid rises SETTLE_CYCLES+1 edges after rom_addr changed. With the default this is E2 for the first word.
- HOLD:
  - out_valid=1; out_data, rom_addr and rom_oeb are stable until the handshake.
  - On an edge with out_ready=1: out_valid<=0 and remaining decrements.
  - If remaining was 1: rom_oeb<=1, busy<=0, done<=1 for exactly one cycle, go to IDLE. rom_addr holds its last value.
  - Else: rom_addr<=rom_addr+1, wrapping modulo 2**ADDR_W (15 -> 0); reload the settle counter; go to SETTLE.
- Throughput with out_ready held high: one word every SETTLE_CYCLES+2 cycles.
- out_ready low in HOLD stalls indefinitely with no data change. out_ready is ignored outside HOLD.
- start asserted while busy is ignored; start_addr and count are sampled only at burst launch.
- A new start is accepted in IDLE on the cycle done is high.
- Reset asserted mid-burst aborts immediately: rom_oeb returns to 1 and no done pulse is issued.

Test Plan:
- Reset check: assert rst mid-cycle with no clock -> rom_oeb=1, out_valid=0, busy=0, rom_addr=0 immediately.
- Full sweep: start_addr=0, count=16, out_ready=1, SETTLE_CYCLES=1 -> 16 words for addresses 0..15, each matching the ROM model.
  - First out_valid at E2, one word per 3 cycles.
  - rom_oeb low from E0 until the last handshake.
  - done pulses once, 48 cycles after start.
- Wrap: start_addr=14, count=4 -> words read at addresses 14, 15, 0, 1 in order, then done.
- Backpressure: start_addr=3, count=2, out_ready held low for 5 cycles on the first word -> out_data stays the ROM[3] value and rom_addr stays 3; after release, ROM[4] follows, then done.
- Zero and clamp: count=0 -> done pulse with rom_oeb never low and no out_valid. count=31 -> exactly 16 words.
- Abort and ignore: start re-asserted while busy is ignored; rst asserted after the 2nd word -> rom_oeb=1 at once, no done. A fresh start then succeeds normally.
